// File: rtl/udc_cfg_sequencer.sv
// udc_cfg_sequencer: host-side controller for the UDC block.
// Accepts one configuration job (PLR/ULR/LLR/CCR) over valid/ready, writes the
// four registers over the UDC strobe bus, pulses start, watches ec/err and
// reports done plus a status code.
// Optional feature macro: UDC_SEQ_READBACK_EN -- read all four registers back
// after writing them and refuse to start the count on any mismatch.
module udc_cfg_sequencer #(
  parameter int unsigned         TO_WIDTH = 16,
  parameter logic [TO_WIDTH-1:0] TO_LIMIT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_plr,
  input  logic [7:0] cfg_ulr,
  input  logic [7:0] cfg_llr,
  input  logic [7:0] cfg_ccr,
  input  logic       abort,
  output logic       udc_ncs,
  output logic       udc_nrd,
  output logic       udc_nwr,
  output logic       udc_a0,
  output logic       udc_a1,
  output logic       udc_start,
  output logic [7:0] udc_dout,
  output logic       udc_oe,
  input  logic [7:0] udc_din,
  input  logic       udc_ec,
  input  logic       udc_err,
  output logic       busy,
  output logic       done,
  output logic [2:0] status
);

  localparam logic [2:0] ST_OK      = 3'b000;
  localparam logic [2:0] ST_RANGE   = 3'b001;
  localparam logic [2:0] ST_TIMEOUT = 3'b010;
  localparam logic [2:0] ST_ABORT   = 3'b011;
  localparam logic [2:0] ST_RB_MIS  = 3'b100;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LATCH,
    S_WR_SETUP,
    S_WR_STROBE,
    S_WR_HOLD,
    S_RB_SETUP,
    S_RB_SAMPLE,
    S_RB_RELEASE,
    S_CHK,
    S_START,
    S_BLANK1,
    S_BLANK2,
    S_WAIT_EC,
    S_KILL,
    S_DONE
  } state_t;

  state_t              st, st_nxt;
  logic [1:0]          idx, idx_nxt;
  logic [TO_WIDTH-1:0] wd, wd_nxt;
  logic [TO_WIDTH:0]   wd_inc;
  logic                mism, mism_nxt;
  logic [2:0]          status_nxt;
  logic                take;
  logic [7:0]          regs [4];
  logic [7:0]          wr_val;

  logic       ncs_nxt, nrd_nxt, nwr_nxt, oe_nxt, start_nxt;
  logic       busy_nxt, done_nxt, ready_nxt;
  logic [1:0] addr_nxt;
  logic [7:0] dout_nxt;

  // One extra bit so the watchdog comparison can never wrap.
  assign wd_inc = {1'b0, wd} + {{TO_WIDTH{1'b0}}, 1'b1};

  // Next-state, bookkeeping and next-output decode; outputs follow the next state
  // so that every output is a clean register aligned with its state.
  always_comb begin
    st_nxt     = st;
    idx_nxt    = idx;
    wd_nxt     = wd;
    mism_nxt   = mism;
    status_nxt = status;
    take       = 1'b0;

    case (st)
      S_IDLE: begin
        if (cfg_valid) begin
          take       = 1'b1;
          st_nxt     = S_LATCH;
          idx_nxt    = 2'd0;
          mism_nxt   = 1'b0;
          status_nxt = ST_OK;
        end
      end
      S_LATCH: begin
        st_nxt  = S_WR_SETUP;
        idx_nxt = 2'd0;
      end
      S_WR_SETUP:  st_nxt = S_WR_STROBE;
      S_WR_STROBE: st_nxt = S_WR_HOLD;
      S_WR_HOLD: begin
        if (idx != 2'd3) begin
          st_nxt  = S_WR_SETUP;
          idx_nxt = idx + 2'd1;
        end else begin
`ifdef UDC_SEQ_READBACK_EN
          st_nxt  = S_RB_SETUP;
          idx_nxt = 2'd0;
`else
          st_nxt  = S_CHK;
`endif
        end
      end
      S_RB_SETUP: st_nxt = S_RB_SAMPLE;
      S_RB_SAMPLE: begin
        st_nxt = S_RB_RELEASE;
        if (udc_din != regs[idx]) mism_nxt = 1'b1;
      end
      S_RB_RELEASE: begin
        if (idx != 2'd3) begin
          st_nxt  = S_RB_SETUP;
          idx_nxt = idx + 2'd1;
        end else if (mism) begin
          st_nxt     = S_DONE;
          status_nxt = ST_RB_MIS;
        end else begin
          st_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (regs[3] == 8'h00) begin
          st_nxt     = S_DONE;
          status_nxt = ST_OK;
        end else begin
          st_nxt = S_START;
        end
      end
      S_START:  st_nxt = S_BLANK1;
      S_BLANK1: st_nxt = S_BLANK2;
      S_BLANK2: begin
        if (udc_err) begin
          st_nxt     = S_DONE;
          status_nxt = ST_RANGE;
        end else begin
          st_nxt = S_WAIT_EC;
          wd_nxt = '0;
        end
      end
      S_WAIT_EC: begin
        if (udc_ec) begin
          st_nxt     = S_DONE;
          status_nxt = ST_OK;
        end else if (wd_inc >= {1'b0, TO_LIMIT}) begin
          st_nxt     = S_KILL;
          status_nxt = ST_TIMEOUT;
          wd_nxt     = TO_LIMIT;
        end else begin
          wd_nxt = wd_inc[TO_WIDTH-1:0];
        end
      end
      S_KILL:  st_nxt = S_DONE;
      S_DONE:  st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase

    // Abort overrides every other outcome; once the UDC may be counting it must be killed.
    if (abort && (st != S_IDLE) && (st != S_DONE)) begin
      status_nxt = ST_ABORT;
      if (st inside {S_START, S_BLANK1, S_BLANK2, S_WAIT_EC}) st_nxt = S_KILL;
      else                                                    st_nxt = S_DONE;
    end

    wr_val    = regs[idx_nxt];
    ncs_nxt   = 1'b1;
    nrd_nxt   = 1'b1;
    nwr_nxt   = 1'b1;
    oe_nxt    = 1'b0;
    start_nxt = 1'b0;
    addr_nxt  = 2'b00;
    dout_nxt  = 8'h00;
    busy_nxt  = (st_nxt != S_IDLE) && (st_nxt != S_DONE);
    done_nxt  = (st_nxt == S_DONE);
    ready_nxt = (st_nxt == S_IDLE);

    case (st_nxt)
      S_WR_SETUP, S_WR_HOLD: begin
        ncs_nxt  = 1'b0;
        addr_nxt = idx_nxt;
        dout_nxt = wr_val;
        oe_nxt   = 1'b1;
      end
      S_WR_STROBE: begin
        ncs_nxt  = 1'b0;
        nwr_nxt  = 1'b0;
        addr_nxt = idx_nxt;
        dout_nxt = wr_val;
        oe_nxt   = 1'b1;
      end
      S_RB_SETUP, S_RB_SAMPLE: begin
        ncs_nxt  = 1'b0;
        nrd_nxt  = 1'b0;
        addr_nxt = idx_nxt;
      end
      S_RB_RELEASE: addr_nxt = idx_nxt;
      S_START:      start_nxt = 1'b1;
      S_KILL: begin
        nwr_nxt = 1'b0;
        nrd_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // State, register index, watchdog, readback flag and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st     <= S_IDLE;
      idx    <= 2'd0;
      wd     <= '0;
      mism   <= 1'b0;
      status <= ST_OK;
    end else begin
      st     <= st_nxt;
      idx    <= idx_nxt;
      wd     <= wd_nxt;
      mism   <= mism_nxt;
      status <= status_nxt;
    end
  end

  // Job values are captured once at the handshake and held for the whole job.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (take) begin
      regs[0] <= cfg_plr;
      regs[1] <= cfg_ulr;
      regs[2] <= cfg_llr;
      regs[3] <= cfg_ccr;
    end
  end

  // Registered bus and handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udc_ncs   <= 1'b1;
      udc_nrd   <= 1'b1;
      udc_nwr   <= 1'b1;
      udc_a1    <= 1'b0;
      udc_a0    <= 1'b0;
      udc_start <= 1'b0;
      udc_dout  <= 8'h00;
      udc_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      udc_ncs   <= ncs_nxt;
      udc_nrd   <= nrd_nxt;
      udc_nwr   <= nwr_nxt;
      udc_a1    <= addr_nxt[1];
      udc_a0    <= addr_nxt[0];
      udc_start <= start_nxt;
      udc_dout  <= dout_nxt;
      udc_oe    <= oe_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cfg_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_udc_cfg_sequencer.sv
// tb_udc_cfg_sequencer: randomized self-checking bench for udc_cfg_sequencer.
// A timeline model of a job (when it ends, with which status, whether start and
// KILL appear, how many writes complete) predicts each observed job.
`timescale 1ns/1ps
module tb_udc_cfg_sequencer;

  localparam int TO_LIM = 16;
`ifdef UDC_SEQ_READBACK_EN
  localparam bit RB_ON = 1'b1;
`else
  localparam bit RB_ON = 1'b0;
`endif
  // Clock offset (after the handshake edge) at which start is high.
  localparam int S_T = RB_ON ? 26 : 14;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_plr = 8'h00, cfg_ulr = 8'h00, cfg_llr = 8'h00, cfg_ccr = 8'h00;
  logic       abort = 1'b0;
  logic       udc_ncs, udc_nrd, udc_nwr, udc_a0, udc_a1, udc_start, udc_oe;
  logic [7:0] udc_dout;
  logic [7:0] udc_din;
  logic       udc_ec = 1'b0, udc_err = 1'b0;
  logic       busy, done;
  logic [2:0] status;

  int total = 0;
  int bad   = 0;

  logic [7:0] udc_reg [4];
  bit         corrupt_llr = 1'b0;

  udc_cfg_sequencer #(.TO_WIDTH(16), .TO_LIMIT(16'd16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr), .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
    .abort(abort),
    .udc_ncs(udc_ncs), .udc_nrd(udc_nrd), .udc_nwr(udc_nwr),
    .udc_a0(udc_a0), .udc_a1(udc_a1), .udc_start(udc_start),
    .udc_dout(udc_dout), .udc_oe(udc_oe), .udc_din(udc_din),
    .udc_ec(udc_ec), .udc_err(udc_err),
    .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  // Minimal UDC register file: captures strobed writes, answers reads (optionally corrupting LLR).
  always @(posedge clk) begin
    if (!udc_ncs && !udc_nwr && udc_nrd) udc_reg[{udc_a1, udc_a0}] <= udc_dout;
  end

  assign udc_din = (!udc_ncs && !udc_nrd)
                   ? ((corrupt_llr && {udc_a1, udc_a0} == 2'd2) ? (udc_reg[2] ^ 8'h01)
                                                               : udc_reg[{udc_a1, udc_a0}])
                   : 8'hFF;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ncs"},   udc_ncs,   1);
    checkOutput({tag, "_nrd"},   udc_nrd,   1);
    checkOutput({tag, "_nwr"},   udc_nwr,   1);
    checkOutput({tag, "_addr"},  {udc_a1, udc_a0}, 0);
    checkOutput({tag, "_start"}, udc_start, 0);
    checkOutput({tag, "_oe"},    udc_oe,    0);
    checkOutput({tag, "_dout"},  udc_dout,  0);
    checkOutput({tag, "_busy"},  busy,      0);
    checkOutput({tag, "_done"},  done,      0);
    checkOutput({tag, "_stat"},  status,    0);
    checkOutput({tag, "_ready"}, cfg_ready, 1);
  endtask

  // Clock offset of the clock in which the job would decide its own outcome.
  function automatic int naturalEnd(input logic [7:0] ccr, input bit err, input int d, input bit corrupt);
    if (RB_ON && corrupt) return S_T - 2;
    if (ccr == 8'h00)     return S_T - 1;
    if (err)              return S_T + 2;
    if (d < TO_LIM)       return S_T + 3 + d;
    return S_T + 2 + TO_LIM;
  endfunction

  // Waits for ready, performs the handshake, runs the job and compares it with the model.
  // t_a < 0 means no abort; d is the number of WAIT_EC clocks before ec rises.
  task automatic applyStimulus(input logic [7:0] plr, input logic [7:0] ulr,
                               input logic [7:0] llr, input logic [7:0] ccr,
                               input bit err, input bit stale, input int d,
                               input int t_a, input bit corrupt);
    logic [7:0]  vals [4];
    logic [10:0] wr_q [$];
    logic [10:0] w;
    int  dec_t, exp_done_t, exp_wr, lim, done_t, start_t, start_cnt, kill_cnt, first_ncs, n;
    bit  exp_start, exp_kill, ab;
    logic [2:0] exp_status;

    vals[0] = plr; vals[1] = ulr; vals[2] = llr; vals[3] = ccr;
    corrupt_llr = corrupt;
    dec_t = naturalEnd(ccr, err, d, corrupt);
    exp_kill  = 1'b0;
    exp_start = !(RB_ON && corrupt) && (ccr != 8'h00);
    if (RB_ON && corrupt)  exp_status = 3'b100;
    else if (ccr == 8'h00) exp_status = 3'b000;
    else if (err)          exp_status = 3'b001;
    else if (d < TO_LIM)   exp_status = 3'b000;
    else begin
      exp_status = 3'b010;
      exp_kill   = 1'b1;
    end
    ab = (t_a >= 0) && (t_a <= dec_t);
    if (ab) begin
      exp_status = 3'b011;
      exp_kill   = (t_a >= S_T);
      exp_start  = exp_start && (t_a >= S_T);
      dec_t      = t_a;
    end
    exp_done_t = dec_t + 1 + (exp_kill ? 1 : 0);
    lim = ab ? t_a : 1000;
    exp_wr = 0;
    for (int i = 0; i < 4; i++) if (3 * i + 2 <= lim) exp_wr++;

    n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_wait", cfg_ready, 1);

    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_plr = plr; cfg_ulr = ulr; cfg_llr = llr; cfg_ccr = ccr;
    @(posedge clk);

    done_t = -1; start_t = -1; start_cnt = 0; kill_cnt = 0; first_ncs = -1;
    for (int t = 0; t < 400 && done_t < 0; t++) begin
      if (t > 0) @(posedge clk);
      #1;
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_plr = 8'($urandom); cfg_ulr = 8'($urandom);
      cfg_llr = 8'($urandom); cfg_ccr = 8'($urandom);
      abort   = (t == t_a);
      udc_err = err;
      udc_ec  = (t < S_T + 3) ? stale : (t >= S_T + 3 + d);
      @(negedge clk);
      if (t == 0) begin
        checkOutput("busy_t0",  busy,      1);
        checkOutput("ready_t0", cfg_ready, 0);
      end
      if (!udc_ncs && first_ncs < 0) first_ncs = t;
      if (!udc_ncs && !udc_nwr && udc_nrd) wr_q.push_back({udc_a1, udc_a0, udc_dout, udc_oe});
      if (udc_start) begin
        start_cnt++;
        start_t = t;
      end
      if (udc_ncs && !udc_nwr && !udc_nrd) kill_cnt++;
      if (done) begin
        done_t = t;
        checkOutput("done_busy",    busy,    0);
        checkOutput("done_strobes", {udc_ncs, udc_nwr, udc_nrd, udc_oe}, 4'b1110);
      end
    end
    cfg_valid = 1'b0;
    abort     = 1'b0;

    checkOutput("done_time",  done_t,    exp_done_t);
    checkOutput("status",     status,    exp_status);
    checkOutput("start_cnt",  start_cnt, exp_start ? 1 : 0);
    if (exp_start) checkOutput("start_time", start_t, S_T);
    checkOutput("kill_cnt",   kill_cnt,  exp_kill ? 1 : 0);
    checkOutput("write_cnt",  wr_q.size(), exp_wr);
    if (exp_wr > 0) checkOutput("first_ncs", first_ncs, 1);
    for (int i = 0; i < wr_q.size() && i < 4; i++) begin
      w = wr_q[i];
      checkOutput("wr_addr", w[10:9], i);
      checkOutput("wr_data", w[8:1],  vals[i]);
      checkOutput("wr_oe",   w[0],    1);
    end

    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("after_done",   done,      0);
    checkOutput("status_hold",  status,    exp_status);
    checkOutput("after_ready",  cfg_ready, 1);
    corrupt_llr = 1'b0;
  endtask

  initial begin
    logic [7:0] p, u, l, c;
    bit  e, s, k;
    int  d, ta, nat, am;

    #3 reset_n = 1'b0;
    #1 checkResetValues("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    $display("[TB] directed jobs");
    applyStimulus(8'd5,  8'd10, 8'd2, 8'd2, 1'b0, 1'b1, 3,  -1, 1'b0);
    applyStimulus(8'd20, 8'd10, 8'd2, 8'd1, 1'b1, 1'b0, 3,  -1, 1'b0);
    applyStimulus(8'd5,  8'd10, 8'd2, 8'd0, 1'b0, 1'b0, 3,  -1, 1'b0);
    applyStimulus(8'd5,  8'd10, 8'd2, 8'd2, 1'b0, 1'b1, 99, -1, 1'b0);
    applyStimulus(8'd5,  8'd10, 8'd2, 8'd2, 1'b0, 1'b0, 3,   5, 1'b0);
    applyStimulus(8'd5,  8'd10, 8'd2, 8'd2, 1'b0, 1'b0, 10, S_T + 5, 1'b0);
    applyStimulus(8'd5,  8'd10, 8'd2, 8'd2, 1'b0, 1'b0, 2,  -1, 1'b1);
    applyStimulus(8'd7,  8'd9,  8'd1, 8'd3, 1'b0, 1'b0, TO_LIM - 1, -1, 1'b0);

    $display("[TB] random jobs");
    for (int j = 0; j < 40; j++) begin
      p = 8'($urandom); u = 8'($urandom); l = 8'($urandom);
      c = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      e = ($urandom_range(0, 4) == 0);
      s = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 4) == 0) ? 99 : int'($urandom_range(0, TO_LIM - 1));
      k = ($urandom_range(0, 7) == 0);
      nat = naturalEnd(c, e, d, k);
      am = int'($urandom_range(0, 3));
      if (am == 0)      ta = int'($urandom_range(0, S_T - 1));
      else if (am == 1) ta = int'($urandom_range(0, nat));
      else              ta = -1;
      applyStimulus(p, u, l, c, e, s, d, ta, k);
    end

    $display("[TB] reset in the middle of a job");
    @(posedge clk); #1;
    cfg_valid = 1'b1;
    cfg_plr = 8'h11; cfg_ulr = 8'h22; cfg_llr = 8'h01; cfg_ccr = 8'h05;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 checkResetValues("midreset");
    @(negedge clk) reset_n = 1'b1;
    applyStimulus(8'd3, 8'd12, 8'd1, 8'd4, 1'b0, 1'b1, 6, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/udc_cfg_sequencer.md
Name: udc_cfg_sequencer

Overview:
- Host-side controller for the up/down counter (UDC) block.
- Takes one configuration job over a valid/ready handshake: PLR, ULR, LLR and CCR values.
- Writes the four registers over the UDC's strobe bus (ncs/nrd/nwr/a1:a0), pulses start, then watches ec/err and reports done plus a status code.
- Sits between the system control logic and the UDC; the top level builds the tristate bus from udc_dout/udc_oe.

Parameters:
- TO_WIDTH, 16, width of the watchdog counter.
- TO_LIMIT, 16'd50000, clocks allowed in WAIT_EC before a timeout is declared.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- cfg_valid  in  1  job request
- cfg_ready  out  1  job accepted when cfg_valid && cfg_ready
- cfg_plr, cfg_ulr, cfg_llr, cfg_ccr  in  8 each  register values for the job
- abort  in  1  cancel the current job
- udc_ncs, udc_nrd, udc_nwr  out  1 each  UDC bus strobes, active-low
- udc_a0, udc_a1  out  1 each  UDC register address
- udc_start  out  1  UDC start pulse
- udc_dout  out  8  write data
- udc_oe  out  1  write-data drive enable for the top-level tristate
- udc_din  in  8  resolved bus value, used for readback
- udc_ec, udc_err  in  1 each  UDC end-of-count and range-error outputs
- busy  out  1  job in progress
- done  out  1  one-clock pulse at job end
- status  out  3  000 OK, 001 RANGE, 010 TIMEOUT, 011 ABORT, 100 RB_MISMATCH

Behaviour:
- Clock and reset (already decided): one clock, clk. reset_n is asynchronous, active-low.
- Reset values: ncs/nrd/nwr = 1, a0/a1 = 0, start = 0, oe = 0, dout = 0, busy = 0, done = 0, status = 000, cfg_ready = 1.
- All outputs are registered.
- IDLE:
  - cfg_ready = 1.
  - On handshake: latch the cfg_* values, drop cfg_ready, set busy; the next clock enters WR.
- WR (three clocks per register, order PLR a1a0=00, ULR 01, LLR 10, CCR 11):
  - SETUP: ncs = 0, address valid, dout = value, oe = 1, nwr = 1.
  - STROBE: nwr = 0.
  - HOLD: nwr = 1, ncs = 0.
  - nrd stays 1 throughout.
  - After CCR HOLD: ncs = 1, oe = 0; go to RB if the feature is enabled, else CHK.
- CHK: if the latched ccr == 0, skip start and finish with status OK. Otherwise go to START.
- START: udc_start = 1 for exactly one clock, with ncs = 1.
- BLANK: two clocks during which udc_ec is ignored, because ec is stale until the UDC clears it. At the second BLANK clock sample udc_err:
  - udc_err = 1 → status RANGE, go to DONE.
  - udc_err = 0 → go to WAIT_EC.
- WAIT_EC:
  - Watchdog counts from 0.
  - udc_ec = 1 → status OK.
  - Watchdog reaches TO_LIMIT → status TIMEOUT, go to KILL.
- KILL: one clock with nwr = 0, nrd = 0, ncs = 1. This clears the UDC's running state. Then go to DONE.
- DONE:
  - done = 1 for one clock; busy = 0; back to IDLE.
  - status holds until the next accepted job.
- Register writes never occur between START and DONE; the UDC ignores writes while counting.
- abort = 1 in any non-IDLE state (sampled each clock):
  - Strobes and oe go inactive on the next clock.
  - From START, BLANK or WAIT_EC: pass through KILL.
  - From any other non-IDLE state: go directly to DONE.
  - status = ABORT.
  - abort in IDLE is ignored. Abort takes priority over simultaneous ec/err/timeout.
- cfg_valid while busy is not accepted (cfg_ready = 0).
- Watchdog does not wrap; it saturates at TO_LIMIT.
- Latency, ccr != 0: handshake → first ncs low = 1 clock; handshake → start pulse = 14 clocks without readback.
- Asserting reset_n low mid-job returns all outputs to reset values immediately. The UDC is reset separately.

Optional Feature:
- Macro UDC_SEQ_READBACK_EN.
- Defined: after CCR is written, RB reads all four registers in the same order. Per register:
  - SETUP: ncs = 0, nrd = 0, nwr = 1, oe = 0.
  - SAMPLE: capture udc_din and compare with the latched value.
  - RELEASE: ncs = 1, nrd = 1.
  - Any mismatch → status RB_MISMATCH, DONE without a start pulse.
- Undefined: RB is absent; WR goes straight to CHK, and status code 100 is never produced.

Test Plan:
- PLR=5, ULR=10, LLR=2, CCR=2 → four write cycles with a1a0=00,01,10,11 and dout 05,0A,02,02; start high for one clock at handshake+14; ec rises; done with status 000.
- PLR=20, ULR=10, LLR=2, CCR=1 → UDC asserts err; done at the second BLANK clock with status 001, no WAIT_EC entered.
- CCR=0 → four writes, no start pulse, done with status 000.
- TO_LIMIT=16, udc_ec forced low → KILL clock with nwr=nrd=0, ncs=1; then status 010.
- abort raised during the ULR STROBE clock → strobes inactive next clock, no start pulse, no KILL, status 011. abort raised in WAIT_EC → KILL pulse, status 011.
- With UDC_SEQ_READBACK_EN and the model corrupting the LLR readback to 0x03 (written 0x02) → status 100, no start pulse. Without the macro the same stimulus gives a start pulse and status 000.
